pwm_timebase: RTL
=================

PWM_TIMEBASE -- requirements
Module: pwm_timebase

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter and auto-reload width.
REQ-002 SHALL have parameter REP_WIDTH, default 8, repetition counter width.
REQ-003 SHALL have port clk_psc_i  input  1  prescaler clock, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ck_cnt_i  input  1  count tick (clock enable from prescaler).
REQ-006 SHALL have port cnt_en_i  input  1  counter enable.
REQ-007 SHALL have port mode_i  input  2  count mode: 00 up, 01 down, 10 center-aligned, 11 treated as up.
REQ-008 SHALL have port opm_i  input  1  one-pulse mode.
REQ-009 SHALL have port ug_i  input  1  software update-generate pulse.
REQ-010 SHALL have port arr_preload_i  input  WIDTH  auto-reload preload.
REQ-011 SHALL have port rep_preload_i  input  REP_WIDTH  repetition preload.
REQ-012 SHALL have port cnt_o  output  WIDTH  counter value.
REQ-013 SHALL have port dir_o  output  1  direction (0 up, 1 down).
REQ-014 SHALL have port overflow_o  output  1  one-cycle boundary-event pulse.
REQ-015 SHALL have port update_o  output  1  one-cycle update-event pulse.
REQ-016 SHALL have port running_o  output  1  high in RUN state.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; IDLE->RUN when cnt_en_i=1; RUN->IDLE and DONE->IDLE when cnt_en_i=0; RUN->DONE on update event when opm_i=1.
REQ-018 SHALL, in IDLE, continuously load arr_shadow<=arr_preload_i, rep_shadow<=rep_preload_i, rep_cnt<=rep_preload_i, mode latch<=mode_i; cnt_o=0 and dir_o=0 for up/center, cnt_o=arr_preload_i and dir_o=1 for down.
REQ-019 SHALL ignore mode_i outside IDLE.
REQ-020 SHALL change cnt_o in RUN only on cycles with ck_cnt_i=1; cnt_o SHALL hold in DONE.
REQ-021 Up: cnt==arr_shadow -> cnt<=0 and boundary event; else cnt+1.
REQ-022 Down: cnt==0 -> cnt<=arr_shadow and boundary event; else cnt-1.
REQ-023 Center: up to arr_shadow, then cnt<=arr_shadow-1, dir_o<=1, boundary event; down to 0, then cnt<=1, dir_o<=0, boundary event.
REQ-024 SHALL, when arr_shadow=0, hold cnt_o at 0 and raise a boundary event on every tick in all modes.
REQ-025 SHALL assert overflow_o for exactly one clk_psc_i cycle, the cycle after the tick that causes a boundary event.
REQ-026 SHALL, on a boundary event, decrement rep_cnt if nonzero; if rep_cnt==0, raise an update event and reload rep_cnt<=rep_shadow.
REQ-027 SHALL, on an update event, reload arr_shadow<=arr_preload_i and rep_shadow<=rep_preload_i, and assert update_o one cycle later for one cycle.
REQ-028 SHALL, on ug_i=1 in RUN: reinitialise cnt_o/dir_o per REQ-018, raise an update event, reload rep_cnt, and suppress any ck_cnt_i action that cycle (ug_i wins).
REQ-029 SHALL ignore ug_i in IDLE and DONE.
REQ-030 SHALL, on cnt_en_i=0 in any cycle, enter IDLE the next cycle, with no overflow_o or update_o pulse from that cycle.

Reset
REQ-031 SHALL, with rst_n_i=0 at a clock edge, set state IDLE, cnt_o=0, dir_o=0, overflow_o=0, update_o=0, running_o=0, and all shadows and rep_cnt to 0, overriding every other input including mid-count.

Configuration
REQ-032 SHALL, with PWM_REP_CNT_EN defined, implement repetition counting per REQ-026.
REQ-033 SHALL, without PWM_REP_CNT_EN, omit rep_cnt/rep_shadow, ignore rep_preload_i (port retained), and raise an update event on every boundary event.

Structure
REQ-034 SHALL take mode encodings (MODE_UP, MODE_DOWN, MODE_CENTER) and the state enumeration from shared package pwm_pkg.
REQ-035 SHALL implement the repetition counter as sub-module pwm_rep_counter (load, decrement, zero flag).

Verification
REQ-036 Up, ARR=3, REP=0, tick every cycle -> cnt 0,1,2,3,0; overflow_o and update_o one cycle after each cnt==3 tick.
REQ-037 Center, ARR=3 -> cnt 0,1,2,3,2,1,0,1; dir_o toggles at 3 and 0; overflow_o after each turn.
REQ-038 Up, ARR=2, REP=2 (PWM_REP_CNT_EN) -> overflow_o every 3 ticks, update_o every 9 ticks; without macro, update_o every 3 ticks.
REQ-039 Down, OPM=1, ARR=4 -> cnt 4,3,2,1,0,4 then held in DONE, running_o=0; cnt_en_i low then high restarts at 4.
REQ-040 ARR preload changed 5->2 mid-period, then ug_i together with ck_cnt_i -> cnt_o=0, update_o next cycle, new period 3 ticks; rst_n_i=0 mid-count -> all outputs 0 next edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// ============================================================================
// pwm_pkg : shared count-mode encodings, FSM states and mode decode helper
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_CENTER = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // The reserved encoding 2'b11 behaves as up-counting.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_DOWN;
      2'b10:   return MODE_CENTER;
      default: return MODE_UP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_rep_counter.sv
// ============================================================================
// pwm_rep_counter : loadable down-counter with zero flag for update skipping
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pwm_rep_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_psc_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_psc_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (dec_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero_o = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/pwm_timebase.sv
// ============================================================================
// pwm_timebase : up/down/center PWM counter with shadowed auto-reload,
//                one-pulse mode and optional repetition counter (PWM_REP_CNT_EN)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int REP_WIDTH = 8
) (
  input  logic                 clk_psc_i,
  input  logic                 rst_n_i,
  input  logic                 ck_cnt_i,
  input  logic                 cnt_en_i,
  input  logic [1:0]           mode_i,
  input  logic                 opm_i,
  input  logic                 ug_i,
  input  logic [WIDTH-1:0]     arr_preload_i,
  input  logic [REP_WIDTH-1:0] rep_preload_i,
  output logic [WIDTH-1:0]     cnt_o,
  output logic                 dir_o,
  output logic                 overflow_o,
  output logic                 update_o,
  output logic                 running_o
);

  state_e           r_state;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_arr_shadow;
  logic             r_dir;
  logic             r_overflow;
  logic             r_update;

  mode_e            w_mode_in;
  logic             w_idle_load;
  logic             w_run;
  logic             w_ug;
  logic             w_tick;
  logic             w_bnd_cond;
  logic             w_boundary;
  logic             w_update;
  logic [WIDTH-1:0] w_cnt_step;
  logic             w_dir_step;

  assign w_mode_in   = decode_mode(mode_i);
  assign w_idle_load = !cnt_en_i || (r_state == ST_IDLE);
  assign w_run       = cnt_en_i && (r_state == ST_RUN);
  assign w_ug        = w_run && ug_i;
  assign w_tick      = w_run && !ug_i && ck_cnt_i;
  assign w_boundary  = w_tick && w_bnd_cond;

  always_comb begin
    w_cnt_step = r_cnt;
    w_dir_step = r_dir;
    w_bnd_cond = 1'b0;
    if (r_arr_shadow == '0) begin
      w_cnt_step = '0;
      w_bnd_cond = 1'b1;
    end else begin
      case (r_mode)
        MODE_DOWN: begin
          if (r_cnt == '0) begin
            w_cnt_step = r_arr_shadow;
            w_bnd_cond = 1'b1;
          end else begin
            w_cnt_step = r_cnt - 1'b1;
          end
        end
        MODE_CENTER: begin
          if (!r_dir && (r_cnt == r_arr_shadow)) begin
            w_cnt_step = r_arr_shadow - 1'b1;
            w_dir_step = 1'b1;
            w_bnd_cond = 1'b1;
          end else if (r_dir && (r_cnt == '0)) begin
            w_cnt_step = {{(WIDTH-1){1'b0}}, 1'b1};
            w_dir_step = 1'b0;
            w_bnd_cond = 1'b1;
          end else begin
            w_cnt_step = r_dir ? (r_cnt - 1'b1) : (r_cnt + 1'b1);
          end
        end
        default: begin
          if (r_cnt == r_arr_shadow) begin
            w_cnt_step = '0;
            w_bnd_cond = 1'b1;
          end else begin
            w_cnt_step = r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PWM_REP_CNT_EN
  logic [REP_WIDTH-1:0] r_rep_shadow;
  logic [REP_WIDTH-1:0] w_rep_val;
  logic                 w_rep_zero;
  logic                 w_rep_load;

  // Only the boundary that finds the repetition count exhausted updates.
  assign w_update   = w_ug || (w_boundary && w_rep_zero);
  assign w_rep_load = w_idle_load || w_update;
  assign w_rep_val  = (w_idle_load || w_ug) ? rep_preload_i : r_rep_shadow;

  pwm_rep_counter #(
    .WIDTH(REP_WIDTH)
  ) u_rep_counter (
    .clk_psc_i  (clk_psc_i),
    .rst_n_i    (rst_n_i),
    .load_i     (w_rep_load),
    .load_val_i (w_rep_val),
    .dec_i      (w_boundary && !w_rep_zero),
    .zero_o     (w_rep_zero)
  );

  always_ff @(posedge clk_psc_i) begin
    if (!rst_n_i) begin
      r_rep_shadow <= '0;
    end else if (w_idle_load || w_update) begin
      r_rep_shadow <= rep_preload_i;
    end
  end
`else
  logic w_unused_rep;
  assign w_unused_rep = ^rep_preload_i;
  assign w_update     = w_ug || w_boundary;
`endif

  always_ff @(posedge clk_psc_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_UP;
      r_cnt        <= '0;
      r_dir        <= 1'b0;
      r_arr_shadow <= '0;
      r_overflow   <= 1'b0;
      r_update     <= 1'b0;
    end else begin
      // Both event terms are already gated by RUN with the enable high.
      r_overflow <= w_boundary;
      r_update   <= w_update;
      if (w_idle_load) begin
        r_state      <= cnt_en_i ? ST_RUN : ST_IDLE;
        r_mode       <= w_mode_in;
        r_arr_shadow <= arr_preload_i;
        r_cnt        <= (w_mode_in == MODE_DOWN) ? arr_preload_i : '0;
        r_dir        <= (w_mode_in == MODE_DOWN);
      end else if (r_state == ST_RUN) begin
        if (w_ug) begin
          r_cnt <= (r_mode == MODE_DOWN) ? arr_preload_i : '0;
          r_dir <= (r_mode == MODE_DOWN);
        end else if (w_tick) begin
          r_cnt <= w_cnt_step;
          r_dir <= w_dir_step;
        end
        if (w_update) begin
          r_arr_shadow <= arr_preload_i;
          if (opm_i) begin
            r_state <= ST_DONE;
          end
        end
      end
    end
  end

  assign cnt_o      = r_cnt;
  assign dir_o      = r_dir;
  assign overflow_o = r_overflow;
  assign update_o   = r_update;
  assign running_o  = (r_state == ST_RUN);

endmodule

`default_nettype wire
